// File: rtl/fetch_ifid_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// and instruction memory.
interface fetch_ifid_stage_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch with IF/ID pipeline register, stall/flush/redirect
// control and a one-entry hold buffer for acks that arrive during a stall.
module fetch_ifid_stage #(
    parameter int                   PC_WIDTH    = 16,
    parameter int                   INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = 16'h0000,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pc_write,
    input  logic                   if_write,
    input  logic                   ifid_flush,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    fetch_ifid_stage_if.master     imem,
    output logic                   ifid_valid,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [PC_WIDTH-1:0]    ifid_pc,
    output logic [PC_WIDTH-1:0]    ifid_pc_plus2,
    output logic [3:0]             op_code,
    output logic [3:0]             op1,
    output logic [3:0]             op2
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] hold_q, hold_d;
    logic                   v_q, v_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    ipc_q, ipc_d;
    logic [PC_WIDTH-1:0]    ipc2_q, ipc2_d;

    logic                   wr;
    logic [PC_WIDTH-1:0]    pc_inc;

    // A flush blocks the load but leaves pc/hold behaving as a stall.
    assign wr     = if_write & ~ifid_flush;
    assign pc_inc = pc_q + PC_WIDTH'(2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            v_q     <= 1'b0;
            instr_q <= NOP_INSTR;
            ipc_q   <= '0;
            ipc2_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            v_q     <= v_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc2_q  <= ipc2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        v_d     = v_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc2_d  = ipc2_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            hold_d  = '0;
            v_d     = 1'b0;
            instr_d = NOP_INSTR;
            state_d = S_WAIT;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_WAIT;
                S_WAIT: begin
                    if (imem.imem_ack) begin
                        if (wr) begin
                            v_d     = 1'b1;
                            instr_d = imem.imem_rdata;
                            ipc_d   = pc_q;
                            ipc2_d  = pc_inc;
                            if (pc_write) pc_d = pc_inc;
                        end else begin
                            hold_d  = imem.imem_rdata;
                            state_d = S_HOLD;
                        end
                    end else if (if_write) begin
                        v_d     = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (wr) begin
                        v_d     = 1'b1;
                        instr_d = hold_q;
                        ipc_d   = pc_q;
                        ipc2_d  = pc_inc;
                        if (pc_write) pc_d = pc_inc;
                        hold_d  = '0;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (ifid_flush) begin
                v_d     = 1'b0;
                instr_d = NOP_INSTR;
            end
        end
    end

    assign imem.imem_req  = (state_q == S_WAIT);
    assign imem.imem_addr = pc_q;

    assign ifid_valid    = v_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc       = ipc_q;
    assign ifid_pc_plus2 = ipc2_q;

    assign op_code = v_q ? instr_q[15:12] : 4'h0;
    assign op1     = v_q ? instr_q[11:8]  : 4'h0;
    assign op2     = v_q ? instr_q[7:4]   : 4'h0;

endmodule
